// File: rtl/tetris_pkg.sv
// Shared types and defaults for the tetris control path: sequencer states,
// player move codes and the default board geometry.
package tetris_pkg;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 4;

  typedef enum logic [3:0] {
    IDLE,
    SPAWN,
    SPAWN_CHK,
    PLAY,
    MOVE,
    FALL,
    LOCK,
    SCAN,
    CLEAR,
    OVER
  } state_t;

  localparam logic [1:0] MV_NONE  = 2'b00;
  localparam logic [1:0] MV_LEFT  = 2'b01;
  localparam logic [1:0] MV_RIGHT = 2'b10;
  localparam logic [1:0] MV_DROP  = 2'b11;

endpackage

// File: rtl/game_sequencer_if.sv
// Player inputs, board datapath flags and command strobes exchanged between
// the game sequencer (master) and the board datapath / player side (slave).
interface game_sequencer_if #(
  parameter int ROWS    = 8,
  parameter int SCORE_W = 8
);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [1:0]         in_move;
  logic               coll_down;
  logic               coll_left;
  logic               coll_right;
  logic               spawn_blocked;
  logic [ROWS-1:0]    row_full;
  logic               cmd_spawn;
  logic               cmd_fall;
  logic               cmd_shift_l;
  logic               cmd_shift_r;
  logic               cmd_lock;
  logic               cmd_clear;
  logic [IDX_W-1:0]   clear_row;
  logic [SCORE_W-1:0] score;
  logic               game_over;

  modport master (
    input  in_move, coll_down, coll_left, coll_right, spawn_blocked, row_full,
    output cmd_spawn, cmd_fall, cmd_shift_l, cmd_shift_r, cmd_lock, cmd_clear,
           clear_row, score, game_over
  );

  modport slave (
    output in_move, coll_down, coll_left, coll_right, spawn_blocked, row_full,
    input  cmd_spawn, cmd_fall, cmd_shift_l, cmd_shift_r, cmd_lock, cmd_clear,
           clear_row, score, game_over
  );
endinterface

// File: rtl/game_sequencer_move_capture.sv
// Turns the raw player move bus into one pending request per button press;
// the newest press wins and the sequencer consumes or flushes it.
module move_capture
  import tetris_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] move,
  input  logic       capture_en,
  input  logic       flush,
  input  logic       consume,
  output logic [1:0] pending
);

  logic [1:0] prev_move;
  logic       req;

  assign req = (move != MV_NONE) && (move != prev_move);

  // A flush at spawn beats a same-cycle press; a press beats a consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_move <= MV_NONE;
      pending   <= MV_NONE;
    end else begin
      prev_move <= move;
      if (flush)
        pending <= MV_NONE;
      else if (req && capture_en)
        pending <= move;
      else if (consume)
        pending <= MV_NONE;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Tetris game controller: drives spawn, moves, gravity, lock, line-clear scan
// and game-over on the board datapath with single-cycle command strobes.
module game_sequencer
  import tetris_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int FALL_DIV = 4,
  parameter int SCORE_W  = 8
) (
  input logic in_clka,
  input logic in_restart,
  game_sequencer_if.master bus
);

  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = $clog2(FALL_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FALL_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROWS - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [SCORE_W-1:0] score, score_n;
  logic [1:0]         pending;
  logic               capture_en, flush, consume;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign capture_en = (state != IDLE) && (state != OVER);
  assign bus.score  = score;

  move_capture u_move_capture (
    .clk        (in_clka),
    .rst        (in_restart),
    .move       (bus.in_move),
    .capture_en (capture_en),
    .flush      (flush),
    .consume    (consume),
    .pending    (pending)
  );

  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      score <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      score <= score_n;
    end
  end

  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    idx_n           = idx;
    score_n         = score;
    flush           = 1'b0;
    consume         = 1'b0;
    bus.cmd_spawn   = 1'b0;
    bus.cmd_fall    = 1'b0;
    bus.cmd_shift_l = 1'b0;
    bus.cmd_shift_r = 1'b0;
    bus.cmd_lock    = 1'b0;
    bus.cmd_clear   = 1'b0;
    bus.clear_row   = '0;
    bus.game_over   = 1'b0;
    case (state)
      IDLE: state_n = SPAWN;
      SPAWN: begin
        bus.cmd_spawn = 1'b1;
        flush         = 1'b1;
        state_n       = SPAWN_CHK;
      end
      SPAWN_CHK: begin
        cnt_n   = '0;
        state_n = bus.spawn_blocked ? OVER : PLAY;
      end
      // Gravity tick outranks a pending move; the move waits one PLAY cycle.
      PLAY: begin
        if (cnt == CNT_LAST)
          state_n = FALL;
        else if (pending != MV_NONE)
          state_n = MOVE;
        else
          cnt_n = cnt + 1'b1;
      end
      MOVE: begin
        consume = 1'b1;
        state_n = PLAY;
        case (pending)
          MV_LEFT:  bus.cmd_shift_l = !bus.coll_left;
          MV_RIGHT: bus.cmd_shift_r = !bus.coll_right;
          MV_DROP:  cnt_n = CNT_LAST;
          default:  ;
        endcase
      end
      FALL: begin
        cnt_n = '0;
        if (bus.coll_down) begin
          state_n = LOCK;
        end else begin
          bus.cmd_fall = 1'b1;
          state_n      = PLAY;
        end
      end
      LOCK: begin
        bus.cmd_lock = 1'b1;
        idx_n        = '0;
        state_n      = SCAN;
      end
      SCAN: begin
        if (bus.row_full[idx])
          state_n = CLEAR;
        else if (idx == IDX_LAST)
          state_n = SPAWN;
        else
          idx_n = idx + 1'b1;
      end
      // idx is left alone: the rows above drop into the cleared row.
      CLEAR: begin
        bus.cmd_clear = 1'b1;
        bus.clear_row = idx;
        score_n       = sat_inc(score);
        state_n       = SCAN;
      end
      OVER: bus.game_over = 1'b1;
      default: state_n = IDLE;
    endcase
  end

endmodule
